pong_engine: RTL
================

# pong_engine

Frame-rate game-state engine for the pong design: owns paddle positions, ball position and velocity, wall and paddle collisions, scoring, serve and game-over sequencing. It is the parametrised successor to the hard-coded paddle/ball registers of the pong top level. Playfield size, sprite geometry, speeds and win score are all parameters. Outputs feed the `sprite` instances directly (`sx`/`sy`); the top level feeds it the VGA frame strobe and the `ui_in[5:0]` buttons.

## Interface
- `H_RES`, 640: playfield width, px
- `V_RES`, 480: playfield height, px
- `PAD_H`, 50: paddle height, px
- `PAD_W`, 8: paddle width, px
- `BALL_SZ`, 8: ball edge length, px
- `P1_X`, 40: P1 paddle left edge (fixed)
- `P2_X`, 600: P2 paddle left edge (fixed)
- `PAD_STEP`, 4: paddle px per frame
- `BALL_SPEED`, 2: ball px per frame per axis
- `SCORE_W`, 4: score counter width
- `WIN_SCORE`, 9: score that ends the game (must be < 2^SCORE_W)
- `POINT_FRAMES`, 60: frames the field is held after a point
- `clk` in 1: system/pixel clock
- `rst` in 1: **synchronous, active-high** reset
- `frame_tick` in 1: one-cycle pulse per frame, from the VGA vsync start
- `btn` in 6: {p2srv, p2dn, p2up, p1srv, p1dn, p1up}, level-sampled at `frame_tick`
- `p1_y`, `p2_y` out 10: paddle top edges
- `ball_x`, `ball_y` out 10: ball top-left corner
- `score1`, `score2` out SCORE_W: player scores
- `state` out 2: 0 SERVE, 1 PLAY, 2 POINT, 3 OVER
- `winner` out 1: 0 = P1, 1 = P2; valid in OVER
- `update_done` out 1: one-cycle pulse on every frame update

## Operation
- Coordinates are top-left, with y growing downward. `up` decrements y; `dn` increments y.
- **Reset values:**
  - `p1_y` = `p2_y` = (V_RES−PAD_H)/2 = 215.
  - `ball_x` = (H_RES−BALL_SZ)/2 = 316; `ball_y` = (V_RES−BALL_SZ)/2 = 236.
  - Scores 0, `state` SERVE, `winner` 0, server = P1, dx = +, dy = +, frame counter 0, `update_done` 0.
- All state changes happen only on cycles where `frame_tick` = 1. At all other times every register holds.
- **Paddles** (SERVE/PLAY/POINT; frozen in OVER):
  - up alone: y −= PAD_STEP; dn alone: y += PAD_STEP; both or neither: hold.
  - Result is clamped to [0, V_RES−PAD_H]. Compute it with ≥11-bit signed width; no wrap.
- **SERVE:** ball held at centre. When the server's `srv` is high: go to PLAY, set dx toward the opponent, keep dy. The other player's `srv` is ignored.
- **PLAY** moves the ball by ±BALL_SPEED on each axis. All checks use pre-update paddle positions.
- Vertical wall:
  - ny ≤ 0 → ny = 0, dy = +.
  - ny ≥ V_RES−BALL_SZ → ny = V_RES−BALL_SZ, dy = −.
- P1 hit: dx = −, nx ≤ P1_X+PAD_W, nx+BALL_SZ > P1_X, ball_y+BALL_SZ > p1_y, ball_y < p1_y+PAD_H → nx = P1_X+PAD_W, dx = +.
- P2 hit: mirror of the P1 rule, with nx+BALL_SZ ≥ P2_X → nx = P2_X−BALL_SZ, dx = −.
- Miss (only when no hit on that frame):
  - nx ≤ 0 → score2 += 1, server = P1.
  - nx ≥ H_RES−BALL_SZ → score1 += 1, server = P2.
  - In both cases: ball re-centred, frame counter cleared, go to POINT.
- Precedence: a paddle hit beats a miss. A wall bounce and a paddle hit in the same frame are both applied.
- **POINT:** ball held at centre. Counter increments once per tick. When the count reaches POINT_FRAMES−1:
  - If either score = WIN_SCORE: go to OVER, `winner` = the player who scored.
  - Otherwise: go to SERVE.
- **OVER:** everything frozen. Either `srv` → scores 0, paddles and ball to reset positions, server = P1, go to SERVE.
- Scores saturate at 2^SCORE_W−1 and never wrap.

## Timing
- Latency is 1 cycle: registers and outputs change on the clock edge that samples `frame_tick` = 1. `update_done` is high for that one following cycle.
- The frame update is single-cycle combinational and must close at pixel clock.
- `rst` overrides `frame_tick` on the same edge.
- Reset in mid-game, including mid-POINT, restores every reset value within one cycle.
- Back-to-back `frame_tick` on consecutive cycles is legal: each tick is one full update.

## Test plan
- Reset, then 10 ticks with no buttons → state 0, paddles 215, ball (316, 236), `update_done` pulses 10 times.
- p1up held 60 ticks → `p1_y` steps 215, 211, … and clamps at 0. p2dn held → `p2_y` clamps at 430. Both up and dn held → no motion.
- SERVE, p2srv then p1srv → p2srv is ignored. After p1srv: state 1, next tick ball (318, 238). Ball at y = 238 with dy = + reaches ball_y = 472 and then decreases.
- Set `p2_y` to span the ball's row, ball heading right → clamps at `ball_x` = 592, dx flips, scores unchanged.
- Paddle away from the ball, ball heading left → `score2` = 1, state 2 for 60 ticks, then state 0 with server P1.
- Script 9 P1 points → state 3, `winner` = 0, `score1` = 9; ticks cause no motion. p2srv → scores 0, state 0.

Source files
------------

// File: rtl/pong_engine.sv
// Frame-rate pong game-state engine: paddles, ball motion, wall/paddle collisions,
// scoring and serve/point/game-over sequencing, advanced once per frame_tick.
module pong_engine #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int PAD_H        = 50,
    parameter int PAD_W        = 8,
    parameter int BALL_SZ      = 8,
    parameter int P1_X         = 40,
    parameter int P2_X         = 600,
    parameter int PAD_STEP     = 4,
    parameter int BALL_SPEED   = 2,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int POINT_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic [5:0]         btn,
    output logic [9:0]         p1_y,
    output logic [9:0]         p2_y,
    output logic [9:0]         ball_x,
    output logic [9:0]         ball_y,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         state,
    output logic               winner,
    output logic               update_done
);
    localparam logic [1:0] S_SERVE = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_POINT = 2'd2;
    localparam logic [1:0] S_OVER  = 2'd3;

    localparam int CNT_W = (POINT_FRAMES > 1) ? $clog2(POINT_FRAMES) : 1;

    localparam logic [9:0]         PAD_HOME  = 10'((V_RES - PAD_H) / 2);
    localparam logic [9:0]         BALL_X0   = 10'((H_RES - BALL_SZ) / 2);
    localparam logic [9:0]         BALL_Y0   = 10'((V_RES - BALL_SZ) / 2);
    localparam logic [9:0]         P1_STOP   = 10'(P1_X + PAD_W);
    localparam logic [9:0]         P2_STOP   = 10'(P2_X - BALL_SZ);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(POINT_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    // Signed 12-bit working values so a move past an edge goes negative rather than wrapping.
    localparam logic signed [11:0] ZERO    = 12'sd0;
    localparam logic signed [11:0] S_STEP  = 12'(PAD_STEP);
    localparam logic signed [11:0] S_SPD   = 12'(BALL_SPEED);
    localparam logic signed [11:0] S_BSZ   = 12'(BALL_SZ);
    localparam logic signed [11:0] S_PADH  = 12'(PAD_H);
    localparam logic signed [11:0] PAD_MAX = 12'(V_RES - PAD_H);
    localparam logic signed [11:0] S_P1X   = 12'(P1_X);
    localparam logic signed [11:0] S_P1R   = 12'(P1_X + PAD_W);
    localparam logic signed [11:0] S_P2X   = 12'(P2_X);
    localparam logic signed [11:0] S_P2R   = 12'(P2_X + PAD_W);
    localparam logic signed [11:0] S_XMAX  = 12'(H_RES - BALL_SZ);
    localparam logic signed [11:0] S_YMAX  = 12'(V_RES - BALL_SZ);

    logic             dx;      // 1 = moving right
    logic             dy;      // 1 = moving down
    logic             server;  // 0 = P1 serves
    logic [CNT_W-1:0] cnt;

    logic [9:0]         nxt_p1, nxt_p2, nxt_ball_x, nxt_ball_y;
    logic [SCORE_W-1:0] nxt_score1, nxt_score2;
    logic [1:0]         nxt_state;
    logic               nxt_winner, nxt_dx, nxt_dy, nxt_server;
    logic [CNT_W-1:0]   nxt_cnt;

    logic signed [11:0] bx, by, py1, py2, step_x, step_y, wall_y;
    logic               wall_dy, hit1, hit2;

    function automatic logic [9:0] move_pad(input logic [9:0] y, input logic up, input logic dn);
        logic signed [11:0] t;
        t = $signed({2'b00, y});
        if (up && !dn) t = t - S_STEP;
        else if (dn && !up) t = t + S_STEP;
        if (t < ZERO) t = ZERO;
        else if (t > PAD_MAX) t = PAD_MAX;
        return t[9:0];
    endfunction

    function automatic logic [SCORE_W-1:0] bump(input logic [SCORE_W-1:0] s);
        return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
    endfunction

    // Candidate ball move and collision tests, all against pre-update paddle positions.
    always_comb begin
        bx      = $signed({2'b00, ball_x});
        by      = $signed({2'b00, ball_y});
        py1     = $signed({2'b00, p1_y});
        py2     = $signed({2'b00, p2_y});
        step_x  = dx ? bx + S_SPD : bx - S_SPD;
        step_y  = dy ? by + S_SPD : by - S_SPD;
        wall_y  = step_y;
        wall_dy = dy;
        if (step_y <= ZERO) begin
            wall_y  = ZERO;
            wall_dy = 1'b1;
        end else if (step_y >= S_YMAX) begin
            wall_y  = S_YMAX;
            wall_dy = 1'b0;
        end
        hit1 = !dx && (step_x <= S_P1R) && (step_x + S_BSZ > S_P1X)
               && (by + S_BSZ > py1) && (by < py1 + S_PADH);
        hit2 = dx && (step_x + S_BSZ >= S_P2X) && (step_x < S_P2R)
               && (by + S_BSZ > py2) && (by < py2 + S_PADH);
    end

    always_comb begin
        nxt_p1     = p1_y;
        nxt_p2     = p2_y;
        nxt_ball_x = ball_x;
        nxt_ball_y = ball_y;
        nxt_score1 = score1;
        nxt_score2 = score2;
        nxt_state  = state;
        nxt_winner = winner;
        nxt_dx     = dx;
        nxt_dy     = dy;
        nxt_server = server;
        nxt_cnt    = cnt;
        if (state != S_OVER) begin
            nxt_p1 = move_pad(p1_y, btn[0], btn[1]);
            nxt_p2 = move_pad(p2_y, btn[3], btn[4]);
        end
        case (state)
            S_SERVE: begin
                nxt_ball_x = BALL_X0;
                nxt_ball_y = BALL_Y0;
                if (server ? btn[5] : btn[2]) begin
                    nxt_state = S_PLAY;
                    nxt_dx    = ~server;
                end
            end
            S_PLAY: begin
                nxt_dy     = wall_dy;
                nxt_ball_y = wall_y[9:0];
                if (hit1) begin
                    nxt_ball_x = P1_STOP;
                    nxt_dx     = 1'b1;
                end else if (hit2) begin
                    nxt_ball_x = P2_STOP;
                    nxt_dx     = 1'b0;
                end else if (step_x <= ZERO || step_x >= S_XMAX) begin
                    if (step_x <= ZERO) begin
                        nxt_score2 = bump(score2);
                        nxt_server = 1'b0;
                    end else begin
                        nxt_score1 = bump(score1);
                        nxt_server = 1'b1;
                    end
                    nxt_ball_x = BALL_X0;
                    nxt_ball_y = BALL_Y0;
                    nxt_cnt    = '0;
                    nxt_state  = S_POINT;
                end else begin
                    nxt_ball_x = step_x[9:0];
                end
            end
            S_POINT: begin
                // The loser serves next, so the scorer is the non-server.
                if (cnt == CNT_LAST) begin
                    if (score1 == WIN || score2 == WIN) begin
                        nxt_state  = S_OVER;
                        nxt_winner = ~server;
                    end else begin
                        nxt_state = S_SERVE;
                    end
                end else begin
                    nxt_cnt = cnt + CNT_W'(1);
                end
            end
            default: begin
                if (btn[2] | btn[5]) begin
                    nxt_score1 = '0;
                    nxt_score2 = '0;
                    nxt_p1     = PAD_HOME;
                    nxt_p2     = PAD_HOME;
                    nxt_ball_x = BALL_X0;
                    nxt_ball_y = BALL_Y0;
                    nxt_server = 1'b0;
                    nxt_state  = S_SERVE;
                end
            end
        endcase
    end

    // frame_tick is a one-cycle strobe with no back-pressure: every high cycle is one full
    // update, and update_done echoes it one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_y        <= PAD_HOME;
            p2_y        <= PAD_HOME;
            ball_x      <= BALL_X0;
            ball_y      <= BALL_Y0;
            score1      <= '0;
            score2      <= '0;
            state       <= S_SERVE;
            winner      <= 1'b0;
            dx          <= 1'b1;
            dy          <= 1'b1;
            server      <= 1'b0;
            cnt         <= '0;
            update_done <= 1'b0;
        end else begin
            update_done <= frame_tick;
            if (frame_tick) begin
                p1_y   <= nxt_p1;
                p2_y   <= nxt_p2;
                ball_x <= nxt_ball_x;
                ball_y <= nxt_ball_y;
                score1 <= nxt_score1;
                score2 <= nxt_score2;
                state  <= nxt_state;
                winner <= nxt_winner;
                dx     <= nxt_dx;
                dy     <= nxt_dy;
                server <= nxt_server;
                cnt    <= nxt_cnt;
            end
        end
    end
endmodule
